// File: rtl/dav_lat_pkg.sv
// Shared types and constants for the DAV latency monitor.
// The package holds the channel FSM encoding, the mode selectors and the measurement-count width.
package dav_lat_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } chan_state_e;

  localparam int MODE_SINGLE = 0;
  localparam int MODE_REARM  = 1;

  localparam int MC_W = 8;

endpackage

// File: rtl/dav_lat_chan.sv
// One latency channel: an IDLE/RUN/DONE FSM with a saturating cycle counter.
// It captures START-to-STOP latency, an overflow flag and a completed-measurement count.
module dav_lat_chan
  import dav_lat_pkg::*;
#(
  parameter int TW   = 8,
  parameter int MODE = MODE_SINGLE,
  parameter int TMR  = 0
) (
  input  logic            clkcms,
  input  logic            clr_fpgarst,
  input  logic            clr,
  input  logic            holdoff,
  input  logic            start,
  input  logic            stop,
  output logic [TW-1:0]   time_out,
  output logic            valid,
  output logic            ovf,
  output logic [MC_W-1:0] meas_cnt
);

  localparam logic [TW-1:0] CNT_MAX = '1;
  localparam int            NREP    = (TMR != 0) ? 3 : 1;

  chan_state_e     state, state_nxt;
  logic [TW-1:0]   cnt_r [NREP];
  logic [TW-1:0]   cnt, cnt_nxt, time_nxt;
  logic            valid_nxt, ovf_nxt;
  logic [MC_W-1:0] mc_nxt;

  if (TMR != 0) begin : g_vote
    assign cnt = (cnt_r[0] & cnt_r[1]) | (cnt_r[0] & cnt_r[2]) | (cnt_r[1] & cnt_r[2]);
  end else begin : g_single
    assign cnt = cnt_r[0];
  end

  // NOTE: every variable gets its hold value first, so no path through the
  // case leaves one unassigned and no latch is inferred.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    time_nxt  = time_out;
    valid_nxt = valid;
    ovf_nxt   = ovf;
    mc_nxt    = meas_cnt;

    unique case (state)
      ST_IDLE: begin
        if (start && !holdoff) begin
          if (stop) begin
            time_nxt  = '0;
            valid_nxt = 1'b1;
            mc_nxt    = meas_cnt + 1'b1;
            state_nxt = ST_DONE;
          end else begin
            cnt_nxt   = TW'(1);
            state_nxt = ST_RUN;
          end
        end
      end
      ST_RUN: begin
        if (holdoff) begin
          state_nxt = ST_IDLE;
        end else if (stop) begin
          time_nxt  = cnt;
          valid_nxt = 1'b1;
          mc_nxt    = meas_cnt + 1'b1;
          state_nxt = ST_DONE;
        end else if (cnt == CNT_MAX) begin
          ovf_nxt = 1'b1;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      ST_DONE: begin
        if (MODE == MODE_REARM) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase

    // Clear wins over any start, stop or capture in the same cycle.
    if (clr) begin
      state_nxt = ST_IDLE;
      cnt_nxt   = '0;
      time_nxt  = '0;
      valid_nxt = 1'b0;
      ovf_nxt   = 1'b0;
      mc_nxt    = '0;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clkcms or posedge clr_fpgarst) begin
    if (clr_fpgarst) begin
      state    <= ST_IDLE;
      time_out <= '0;
      valid    <= 1'b0;
      ovf      <= 1'b0;
      meas_cnt <= '0;
      // NOTE: counter replicas are all reset so the majority vote starts consistent.
      for (int i = 0; i < NREP; i++) cnt_r[i] <= '0;
    end else begin
      state    <= state_nxt;
      time_out <= time_nxt;
      valid    <= valid_nxt;
      ovf      <= ovf_nxt;
      meas_cnt <= mc_nxt;
      for (int i = 0; i < NREP; i++) cnt_r[i] <= cnt_nxt;
    end
  end

endmodule

// File: rtl/dav_lat_monitor.sv
// Multi-channel START-to-STOP latency monitor with a prescaled power-on holdoff.
// The per-channel results are read out through the JTAG readout path.
module dav_lat_monitor
  import dav_lat_pkg::*;
#(
  parameter int NCH     = 4,
  parameter int TW      = 8,
  parameter int POH_W   = 8,
  parameter int POH_DIV = 0,
  parameter int MODE    = MODE_SINGLE,
  parameter int TMR     = 0
) (
  input  logic                clkcms,
  input  logic                clr_fpgarst,
  input  logic                fpgarst,
  input  logic                clr,
  input  logic [NCH-1:0]      start,
  input  logic [NCH-1:0]      stop,
  output logic                holdoff,
  output logic [NCH*TW-1:0]   time_out,
  output logic [NCH-1:0]      valid,
  output logic [NCH-1:0]      ovf,
  output logic [NCH*MC_W-1:0] meas_cnt
);

  localparam int PW = (POH_DIV > 0) ? POH_DIV : 1;

  logic [POH_W-1:0] poh_cnt;
  logic [PW-1:0]    presc;
  logic             tick, release_poh, holdoff_nxt;

  assign tick        = (POH_DIV == 0) ? 1'b1 : (presc == {PW{1'b1}});
  // A live fpgarst blocks release so holding it high keeps holdoff asserted.
  assign release_poh = (&poh_cnt) & tick & ~fpgarst;
  assign holdoff_nxt = ~release_poh & (fpgarst | holdoff);

  always_ff @(posedge clkcms or posedge clr_fpgarst) begin
    if (clr_fpgarst) begin
      holdoff <= 1'b1;
      poh_cnt <= '0;
      presc   <= '0;
    end else begin
      holdoff <= holdoff_nxt;
      if (!holdoff || fpgarst) begin
        poh_cnt <= '0;
        presc   <= '0;
      end else begin
        presc <= presc + 1'b1;
        if (tick) poh_cnt <= poh_cnt + 1'b1;
      end
    end
  end

  for (genvar i = 0; i < NCH; i++) begin : g_chan
    dav_lat_chan #(
      .TW  (TW),
      .MODE(MODE),
      .TMR (TMR)
    ) u_chan (
      .clkcms     (clkcms),
      .clr_fpgarst(clr_fpgarst),
      .clr        (clr),
      .holdoff    (holdoff),
      .start      (start[i]),
      .stop       (stop[i]),
      .time_out   (time_out[i*TW +: TW]),
      .valid      (valid[i]),
      .ovf        (ovf[i]),
      .meas_cnt   (meas_cnt[i*MC_W +: MC_W])
    );
  end

endmodule

// File: tb/tb_dav_lat_monitor.sv
// Scoreboard bench for dav_lat_monitor: single-shot/TW=8, re-arm/TW=4 and prescaled-holdoff instances.
// Expected results are queued when stimulus is issued and popped when a channel's count moves.
module tb_dav_lat_monitor;

  logic        clkcms = 1'b0;
  logic        clr_fpgarst, fpgarst, clr;
  logic [3:0]  start, stop;
  logic        start_c, stop_c;

  logic        holdoff_a, holdoff_b, holdoff_c;
  logic [31:0] to_a;
  logic [15:0] to_b;
  logic [7:0]  to_c;
  logic [3:0]  valid_a, valid_b, ovf_a, ovf_b;
  logic        valid_c, ovf_c;
  logic [31:0] mc_a, mc_b;
  logic [7:0]  mc_c;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int ch;
    int t;
    int o;
    int mc;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];

  always #5 clkcms = ~clkcms;

  dav_lat_monitor #(.NCH(4), .TW(8), .POH_W(4), .POH_DIV(0), .MODE(0), .TMR(0)) dut_a (
    .clkcms(clkcms), .clr_fpgarst(clr_fpgarst), .fpgarst(fpgarst), .clr(clr),
    .start(start), .stop(stop), .holdoff(holdoff_a), .time_out(to_a),
    .valid(valid_a), .ovf(ovf_a), .meas_cnt(mc_a)
  );

  dav_lat_monitor #(.NCH(4), .TW(4), .POH_W(4), .POH_DIV(0), .MODE(1), .TMR(1)) dut_b (
    .clkcms(clkcms), .clr_fpgarst(clr_fpgarst), .fpgarst(fpgarst), .clr(clr),
    .start(start), .stop(stop), .holdoff(holdoff_b), .time_out(to_b),
    .valid(valid_b), .ovf(ovf_b), .meas_cnt(mc_b)
  );

  dav_lat_monitor #(.NCH(1), .TW(8), .POH_W(4), .POH_DIV(1), .MODE(0), .TMR(0)) dut_c (
    .clkcms(clkcms), .clr_fpgarst(clr_fpgarst), .fpgarst(fpgarst), .clr(clr),
    .start(start_c), .stop(stop_c), .holdoff(holdoff_c), .time_out(to_c),
    .valid(valid_c), .ovf(ovf_c), .meas_cnt(mc_c)
  );

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic push_a(input int ch, input int t, input int o, input int mc);
    exp_t e;
    e.ch = ch; e.t = t; e.o = o; e.mc = mc;
    qa.push_back(e);
  endtask

  task automatic push_b(input int ch, input int t, input int o, input int mc);
    exp_t e;
    e.ch = ch; e.t = t; e.o = o; e.mc = mc;
    qb.push_back(e);
  endtask

  task automatic sb_pop(input int dut, input int ch);
    exp_t e;
    if (dut == 0) begin
      if (qa.size() == 0) begin
        check($sformatf("a_unexpected_result_ch%0d", ch), qa.size(), 1);
      end else begin
        e = qa.pop_front();
        check("a_channel", ch, e.ch);
        check($sformatf("a_time_ch%0d", ch), int'(to_a[ch*8 +: 8]), e.t);
        check($sformatf("a_ovf_ch%0d", ch), int'(ovf_a[ch]), e.o);
        check($sformatf("a_meas_ch%0d", ch), int'(mc_a[ch*8 +: 8]), e.mc);
        check($sformatf("a_valid_ch%0d", ch), int'(valid_a[ch]), 1);
      end
    end else begin
      if (qb.size() == 0) begin
        check($sformatf("b_unexpected_result_ch%0d", ch), qb.size(), 1);
      end else begin
        e = qb.pop_front();
        check("b_channel", ch, e.ch);
        check($sformatf("b_time_ch%0d", ch), int'(to_b[ch*4 +: 4]), e.t);
        check($sformatf("b_ovf_ch%0d", ch), int'(ovf_b[ch]), e.o);
        check($sformatf("b_meas_ch%0d", ch), int'(mc_b[ch*8 +: 8]), e.mc);
        check($sformatf("b_valid_ch%0d", ch), int'(valid_b[ch]), 1);
      end
    end
  endtask

  // Monitor: a moving measurement count is the output event; clr-induced changes are skipped.
  logic [31:0] mc_a_prev = '0;
  logic [31:0] mc_b_prev = '0;
  logic        clr_prev  = 1'b0;

  always @(negedge clkcms) begin
    if (!clr_fpgarst && !clr_prev) begin
      for (int ch = 0; ch < 4; ch++) begin
        if (mc_a[ch*8 +: 8] != mc_a_prev[ch*8 +: 8]) sb_pop(0, ch);
        if (mc_b[ch*8 +: 8] != mc_b_prev[ch*8 +: 8]) sb_pop(1, ch);
      end
    end
    mc_a_prev <= mc_a;
    mc_b_prev <= mc_b;
    clr_prev  <= clr;
  end

  task automatic step(input int n);
    repeat (n) @(posedge clkcms);
    #1;
  endtask

  // start sampled at edge t, stop at edge t+k.
  task automatic measure(input int ch, input int k);
    start[ch] = 1'b1;
    step(1);
    start[ch] = 1'b0;
    step(k - 1);
    stop[ch] = 1'b1;
    step(1);
    stop[ch] = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int na, nb, nc, nf, zero_ok;

    clr_fpgarst = 1'b1;
    fpgarst     = 1'b0;
    clr         = 1'b0;
    start       = '0;
    stop        = '0;
    start_c     = 1'b0;
    stop_c      = 1'b0;
    step(3);

    check("rst_holdoff_a", int'(holdoff_a), 1);
    check("rst_holdoff_c", int'(holdoff_c), 1);
    check("rst_time_a", int'(to_a != 0), 0);
    check("rst_valid_ovf_a", int'({valid_a, ovf_a}), 0);
    check("rst_meas_b", int'(mc_b != 0), 0);

    clr_fpgarst = 1'b0;

    // Power-on holdoff length; start[2] at edge 3 falls inside it.
    na = -1; nb = -1; nc = -1; zero_ok = 1;
    for (int n = 1; n <= 100 && nc < 0; n++) begin
      if (n == 3) start[2] = 1'b1;
      step(1);
      if (n == 3) start[2] = 1'b0;
      if (na < 0 && !holdoff_a) na = n;
      if (nb < 0 && !holdoff_b) nb = n;
      if (nc < 0 && !holdoff_c) nc = n;
      if (to_a != 0 || valid_a != 0 || ovf_a != 0 || to_b != 0 || valid_b != 0 ||
          ovf_b != 0 || to_c != 0 || valid_c || ovf_c || mc_c != 0)
        zero_ok = 0;
    end
    check("holdoff_len_a", na, 16);
    check("holdoff_len_b", nb, 16);
    check("holdoff_len_prescaled_c", nc, 32);
    check("outputs_zero_during_holdoff", zero_ok, 1);

    // A lone stop on channel 2 must not capture if the holdoff start was ignored.
    step(2);
    stop[2] = 1'b1;
    step(1);
    stop[2] = 1'b0;
    step(2);

    push_a(0, 37, 0, 1);
    push_b(0, 15, 1, 1);
    measure(0, 37);
    step(2);
    check("valid_after_ch0_a", int'(valid_a), 1);
    check("valid_after_ch0_b", int'(valid_b), 1);

    push_a(1, 20, 0, 1);
    push_b(1, 15, 1, 1);
    measure(1, 20);
    step(2);
    check("ovf_vec_a", int'(ovf_a), 0);
    check("ovf_vec_b", int'(ovf_b), 3);

    // Single-shot keeps the first result; re-arm takes both.
    push_a(3, 5, 0, 1);
    push_b(3, 5, 0, 1);
    push_b(3, 9, 0, 2);
    measure(3, 5);
    step(3);
    measure(3, 9);
    step(2);
    check("mode_single_time", int'(to_a[31:24]), 5);
    check("mode_single_meas", int'(mc_a[31:24]), 1);
    check("mode_rearm_time", int'(to_b[15:12]), 9);
    check("mode_rearm_meas", int'(mc_b[31:24]), 2);

    // Channel 2 running when fpgarst is held longer than the holdoff length.
    start[2] = 1'b1;
    step(1);
    start[2] = 1'b0;
    step(3);
    fpgarst = 1'b1;
    step(20);
    check("holdoff_held_by_fpgarst", int'(holdoff_a), 1);
    fpgarst = 1'b0;
    nf = -1;
    for (int n = 1; n <= 100 && nf < 0; n++) begin
      step(1);
      if (!holdoff_a) nf = n;
    end
    check("holdoff_len_after_fpgarst", nf, 16);
    step(2);
    stop[2] = 1'b1;
    step(1);
    stop[2] = 1'b0;
    step(2);
    check("abort_valid2_a", int'(valid_a[2]), 0);
    check("abort_valid2_b", int'(valid_b[2]), 0);
    check("abort_meas2_a", int'(mc_a[23:16]), 0);

    clr = 1'b1;
    step(1);
    clr = 1'b0;
    step(1);
    check("clr_time_a", int'(to_a != 0), 0);
    check("clr_flags_a", int'({valid_a, ovf_a}), 0);
    check("clr_meas_a", int'(mc_a != 0), 0);
    check("clr_flags_b", int'({valid_b, ovf_b}), 0);
    check("clr_meas_b", int'(mc_b != 0), 0);
    check("clr_keeps_holdoff", int'(holdoff_a), 0);

    // clr beats a stop arriving in the same cycle.
    start[3] = 1'b1;
    step(1);
    start[3] = 1'b0;
    step(4);
    stop[3] = 1'b1;
    clr     = 1'b1;
    step(1);
    stop[3] = 1'b0;
    clr     = 1'b0;
    step(2);
    check("clr_vs_stop_time_a", int'(to_a[31:24]), 0);
    check("clr_vs_stop_valid_a", int'(valid_a[3]), 0);
    check("clr_vs_stop_valid_b", int'(valid_b[3]), 0);

    // start and stop together from IDLE: zero-latency result.
    push_a(3, 0, 0, 1);
    push_b(3, 0, 0, 1);
    start[3] = 1'b1;
    stop[3]  = 1'b1;
    step(1);
    start[3] = 1'b0;
    stop[3]  = 1'b0;
    step(3);
    check("same_cycle_valid_a", int'(valid_a[3]), 1);
    check("pending_a", qa.size(), 0);
    check("pending_b", qb.size(), 0);

    // Asynchronous reset takes effect without a clock edge.
    start[0] = 1'b1;
    step(1);
    start[0] = 1'b0;
    step(2);
    #2;
    clr_fpgarst = 1'b1;
    #1;
    check("async_rst_valid_a", int'(valid_a), 0);
    check("async_rst_meas_a", int'(mc_a != 0), 0);
    check("async_rst_holdoff_a", int'(holdoff_a), 1);
    step(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dav_lat_monitor.md
Name: dav_lat_monitor

Overview:
- Multi-channel latency monitor: measures clkcms cycles from each channel's START event (LCT, CFEB/TMB/ALCT DAV) to its STOP event (GFPUSH/DPUSH).
- Integrated power-on holdoff with prescaled counter.
- Parametrised successor to the fixed four-timer arrangement in the trigger/DAV path: generalises channel count and timer width, and adds overflow flags, re-arm mode and measurement counting.
- Results are read by the JTAG readout path.

Parameters:
- NCH, 4, number of independent timer channels
- TW, 8, timer width in bits; saturating
- POH_W, 8, power-on holdoff counter width
- POH_DIV, 0, holdoff counter advances once every 2^POH_DIV clkcms cycles
- MODE, 0, 0 = single-shot (first measurement held until clear); 1 = re-arm (every measurement overwrites)
- TMR, 0, passed to counter instances

Ports:
- clkcms  in  1  system clock
- clr_fpgarst  in  1  asynchronous reset, active-high
- fpgarst  in  1  synchronous holdoff trigger (level)
- clr  in  1  synchronous clear of all channel results (jreadout)
- start  in  NCH  per-channel start strobe
- stop  in  NCH  per-channel stop strobe
- holdoff  out  1  power-on holdoff active
- time_out  out  NCH*TW  channel i result in bits [i*TW +: TW]
- valid  out  NCH  sticky: channel has a result
- ovf  out  NCH  sticky: channel saturated
- meas_cnt  out  NCH*8  per-channel completed-measurement count, wraps 255 -> 0

Behaviour:
- Reset values:
  - holdoff = 1; holdoff counter = 0; prescaler = 0.
  - All channels in IDLE; time_out, valid, ovf, meas_cnt = 0.
- Holdoff:
  - holdoff_next = ~release & (fpgarst | holdoff).
  - release = holdoff counter all-ones AND prescaler tick.
  - Counter and prescaler advance only while holdoff = 1, and are cleared while holdoff = 0.
  - Holdoff duration after reset or fpgarst = 2^POH_W * 2^POH_DIV cycles.
  - fpgarst held high keeps holdoff = 1 indefinitely. Once fpgarst falls, holdoff lasts the full duration from counter 0 (counter is cleared while fpgarst = 1).
- Channel FSM, states IDLE, RUN, DONE; 2-bit encoding from the package.
  - IDLE, start = 1, holdoff = 0, stop = 0: go to RUN, cnt = 1 at next edge.
  - IDLE, start = 1, stop = 1 same cycle: result 0, go to DONE.
  - RUN, each cycle: cnt += 1, saturating at 2^TW-1. ovf sets the cycle cnt would exceed 2^TW-1.
  - RUN, stop = 1: time_out = cnt, valid = 1, meas_cnt += 1, go to DONE.
  - Result definition: start sampled at edge t, stop at edge t+k gives time_out = min(k, 2^TW-1).
  - DONE, MODE = 0: hold state; start and stop ignored until clr.
  - DONE, MODE = 1: return to IDLE next cycle. A start in the DONE cycle is ignored.
  - Start while in RUN is ignored (no restart). Stop while in IDLE is ignored.
- Holdoff rises during RUN: channel aborts to IDLE. No capture; time_out, valid, ovf and meas_cnt are unchanged.
- clr:
  - All channels go to IDLE; time_out, valid, ovf, meas_cnt = 0.
  - clr beats simultaneous start, stop or capture.
  - Does not affect holdoff.
- Output timing: all outputs registered; time_out and valid update one edge after the stop sample.
- Async reset mid-operation: immediate return to reset values.

Decomposition:
- Package dav_lat_pkg:
  - state encodings ST_IDLE = 2'd0, ST_RUN = 2'd1, ST_DONE = 2'd2
  - MODE_SINGLE = 0, MODE_REARM = 1
  - meas_cnt width constant MC_W = 8
- Sub-module dav_lat_chan: one channel FSM plus saturating counter, parameters TW and MODE. Generated NCH times.
- Top level holds the holdoff logic and prescaler.

Test Plan:
- Reset, POH_W=4, POH_DIV=0, no fpgarst -> holdoff = 1 for exactly 16 cycles, then 0; time_out, valid, ovf all 0 throughout.
- After holdoff, start[0] at edge 100, stop[0] at edge 137 -> time_out[7:0] = 37, valid[0] = 1, meas_cnt[0] = 1; other channels unchanged.
- TW=4, start[1] then stop[1] 20 cycles later -> time_out = 15, ovf[1] = 1, valid[1] = 1.
- MODE=0, two start/stop pairs of 5 then 9 cycles -> time_out = 5, meas_cnt = 1. MODE=1, same stimulus -> time_out = 9, meas_cnt = 2.
- start[2] during holdoff -> ignored. Channel 2 in RUN, fpgarst pulsed -> abort, valid[2] stays 0.
- clr coincident with stop[3] in RUN -> time_out = 0, valid = 0. start and stop in the same cycle from IDLE -> time_out = 0, valid = 1.
